// File: rtl/control_unit_if.sv
// Control unit signal bundle: instruction/handshake inputs and control strobes.
// The master modport is the control unit. The slave modport is the datapath or
// memory side that feeds it.
interface control_unit_if;
  logic [7:0] ir_value;
  logic       mem_ack;
  logic       step;
  logic       mem_req;
  logic       ir_write;
  logic       pc_inc;
  logic       gp_reg_write;
  logic       gp_reg_read;
  logic       latch_ula;
  logic       grab_ula;
  logic [3:0] ula_operation;
  logic       halted;
  logic       illegal_op;
  logic [7:0] instr_count;

  modport master (
    input  ir_value, mem_ack, step,
    output mem_req, ir_write, pc_inc, gp_reg_write, gp_reg_read,
           latch_ula, grab_ula, ula_operation, halted, illegal_op, instr_count
  );

  modport slave (
    output ir_value, mem_ack, step,
    input  mem_req, ir_write, pc_inc, gp_reg_write, gp_reg_read,
           latch_ula, grab_ula, ula_operation, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit FSM for the 8-bit accumulator CPU.
// Every output is registered, and it is computed from the next state, so the
// outputs line up with the current state as Moore outputs.
// Optional macro CTRL_SINGLE_STEP_EN: DECODE waits for a step pulse before it
// dispatches the instruction.
module control_unit (
  input  logic          clock,
  input  logic          reset,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, LOAD_IR, DECODE, OPERAND, WRITE_A, ALU_EXEC, OUT_EXEC, HALT
  } state_t;

  state_t     state_reg, state_next;
  logic       decode_exit, decode_illegal;

  logic       mem_req_reg, mem_req_next;
  logic       ir_write_reg, ir_write_next;
  logic       pc_inc_reg, pc_inc_next;
  logic       gp_reg_write_reg, gp_reg_write_next;
  logic       gp_reg_read_reg, gp_reg_read_next;
  logic       latch_ula_reg, latch_ula_next;
  logic       grab_ula_reg, grab_ula_next;
  logic [3:0] ula_operation_reg, ula_operation_next;
  logic       halted_reg, halted_next;
  logic       illegal_op_reg, illegal_op_next;
  logic [7:0] instr_count_reg, instr_count_next;

  wire [3:0] opcode = bus.ir_value[7:4];

`ifndef CTRL_SINGLE_STEP_EN
  // step only matters in single-step builds.
  logic unused_step;
  assign unused_step = bus.step;
`endif

  // State and registered outputs. Reset clears every strobe, including mem_req.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= FETCH;
      mem_req_reg       <= 1'b0;
      ir_write_reg      <= 1'b0;
      pc_inc_reg        <= 1'b0;
      gp_reg_write_reg  <= 1'b0;
      gp_reg_read_reg   <= 1'b0;
      latch_ula_reg     <= 1'b0;
      grab_ula_reg      <= 1'b0;
      ula_operation_reg <= 4'h0;
      halted_reg        <= 1'b0;
      illegal_op_reg    <= 1'b0;
      instr_count_reg   <= 8'h00;
    end else begin
      state_reg         <= state_next;
      mem_req_reg       <= mem_req_next;
      ir_write_reg      <= ir_write_next;
      pc_inc_reg        <= pc_inc_next;
      gp_reg_write_reg  <= gp_reg_write_next;
      gp_reg_read_reg   <= gp_reg_read_next;
      latch_ula_reg     <= latch_ula_next;
      grab_ula_reg      <= grab_ula_next;
      ula_operation_reg <= ula_operation_next;
      halted_reg        <= halted_next;
      illegal_op_reg    <= illegal_op_next;
      instr_count_reg   <= instr_count_next;
    end
  end

  // Next-state logic. mem_ack only counts while a request is actually out.
  always_comb begin
    state_next     = state_reg;
    decode_exit    = 1'b0;
    decode_illegal = 1'b0;
    case (state_reg)
      FETCH:    if (mem_req_reg && bus.mem_ack) state_next = LOAD_IR;
      LOAD_IR:  state_next = DECODE;
      DECODE: begin
`ifdef CTRL_SINGLE_STEP_EN
        decode_exit = bus.step;
`else
        decode_exit = 1'b1;
`endif
        if (decode_exit) begin
          case (opcode)
            4'h0:    state_next = FETCH;
            4'h1:    state_next = OPERAND;
            4'h2:    state_next = ALU_EXEC;
            4'h3:    state_next = OUT_EXEC;
            4'hF:    state_next = HALT;
            default: begin
              state_next     = FETCH;
              decode_illegal = 1'b1;
            end
          endcase
        end
      end
      OPERAND:  if (mem_req_reg && bus.mem_ack) state_next = WRITE_A;
      WRITE_A:  state_next = FETCH;
      ALU_EXEC: state_next = FETCH;
      OUT_EXEC: state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = FETCH;
    endcase
  end

  // Output decode of the state being entered, so the registers match it next cycle.
  always_comb begin
    mem_req_next       = 1'b0;
    ir_write_next      = 1'b0;
    pc_inc_next        = 1'b0;
    gp_reg_write_next  = 1'b0;
    gp_reg_read_next   = 1'b0;
    latch_ula_next     = 1'b0;
    grab_ula_next      = 1'b0;
    ula_operation_next = 4'h0;
    halted_next        = 1'b0;
    illegal_op_next    = decode_illegal;
    instr_count_next   = instr_count_reg;
    if (decode_exit) instr_count_next = instr_count_reg + 8'd1;
    case (state_next)
      FETCH, OPERAND: mem_req_next = 1'b1;
      LOAD_IR: begin
        ir_write_next = 1'b1;
        pc_inc_next   = 1'b1;
      end
      WRITE_A: begin
        gp_reg_write_next = 1'b1;
        pc_inc_next       = 1'b1;
      end
      ALU_EXEC: begin
        gp_reg_read_next   = 1'b1;
        latch_ula_next     = 1'b1;
        ula_operation_next = bus.ir_value[3:0];
      end
      OUT_EXEC: grab_ula_next = 1'b1;
      HALT:     halted_next   = 1'b1;
      default:  ;
    endcase
  end

  assign bus.mem_req       = mem_req_reg;
  assign bus.ir_write      = ir_write_reg;
  assign bus.pc_inc        = pc_inc_reg;
  assign bus.gp_reg_write  = gp_reg_write_reg;
  assign bus.gp_reg_read   = gp_reg_read_reg;
  assign bus.latch_ula     = latch_ula_reg;
  assign bus.grab_ula      = grab_ula_reg;
  assign bus.ula_operation = ula_operation_reg;
  assign bus.halted        = halted_reg;
  assign bus.illegal_op    = illegal_op_reg;
  assign bus.instr_count   = instr_count_reg;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. Each instruction is expanded into the cycle-by-cycle
// output trace that the instruction rules require. The bench then replays that
// trace against the DUT and compares it cycle by cycle.
module tb_control_unit;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  control_unit_if bus();

  control_unit dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Expected-output layout:
  // {mem_req, ir_write, pc_inc, gp_w, gp_r, latch, grab, ula[3:0], halted, illegal, count[7:0]}
  typedef struct {
    logic        ack;
    logic        stp;
    logic [7:0]  ir;
    logic [20:0] exp;
  } cyc_t;

  cyc_t       trace[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_count;
  logic       pend_illegal;

  function automatic logic [20:0] observed();
    return {bus.mem_req, bus.ir_write, bus.pc_inc, bus.gp_reg_write, bus.gp_reg_read,
            bus.latch_ula, bus.grab_ula, bus.ula_operation, bus.halted,
            bus.illegal_op, bus.instr_count};
  endfunction

  task automatic push_cycle(input logic ack, input logic stp, input logic [7:0] ir,
                            input logic [6:0] strobes, input logic [3:0] op,
                            input logic halt);
    cyc_t c;
    c.ack = ack;
    c.stp = stp;
    c.ir  = ir;
    c.exp = {strobes, op, halt, pend_illegal, model_count};
    pend_illegal = 1'b0;
    trace.push_back(c);
  endtask

  // Expand one instruction into expected cycles.
  // fdly and odly are the wait cycles before mem_ack in FETCH and in OPERAND.
  // For HLT, odly is the number of halted cycles to observe.
  // hold is the number of extra DECODE cycles, used only in single-step builds.
  task automatic add_instr(input logic [7:0] ir, input int fdly, input int odly,
                           input int hold);
    logic [3:0] opc;
    opc = ir[7:4];
    for (int i = 0; i < fdly; i++) push_cycle(1'b0, 1'($urandom), ir, 7'b1000000, 4'h0, 1'b0);
    push_cycle(1'b1, 1'($urandom), ir, 7'b1000000, 4'h0, 1'b0);
    push_cycle(1'($urandom), 1'($urandom), ir, 7'b0110000, 4'h0, 1'b0);
`ifdef CTRL_SINGLE_STEP_EN
    for (int i = 0; i < hold; i++) push_cycle(1'($urandom), 1'b0, ir, 7'b0, 4'h0, 1'b0);
    push_cycle(1'($urandom), 1'b1, ir, 7'b0, 4'h0, 1'b0);
`else
    if (hold < 0) $display("unexpected hold value");
    push_cycle(1'($urandom), 1'($urandom), ir, 7'b0, 4'h0, 1'b0);
`endif
    model_count = model_count + 8'd1;
    case (opc)
      4'h0: ;
      4'h1: begin
        for (int i = 0; i < odly; i++) push_cycle(1'b0, 1'($urandom), ir, 7'b1000000, 4'h0, 1'b0);
        push_cycle(1'b1, 1'($urandom), ir, 7'b1000000, 4'h0, 1'b0);
        push_cycle(1'($urandom), 1'($urandom), ir, 7'b0011000, 4'h0, 1'b0);
      end
      4'h2: push_cycle(1'($urandom), 1'($urandom), ir, 7'b0000110, ir[3:0], 1'b0);
      4'h3: push_cycle(1'($urandom), 1'($urandom), ir, 7'b0000001, 4'h0, 1'b0);
      4'hF: for (int i = 0; i < odly; i++) push_cycle(1'($urandom), 1'($urandom), ir, 7'b0, 4'h0, 1'b1);
      default: pend_illegal = 1'b1;
    endcase
  endtask

  // Replay up to 'limit' trace cycles, called at a falling edge.
  // Any cycles left over are discarded.
  task automatic run_trace(input string name, input int limit);
    cyc_t e;
    int   n;
    n = 0;
    while (trace.size() > 0 && n < limit) begin
      e = trace.pop_front();
      n_tests++;
      if (observed() !== e.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %06h expected %06h", name, n, observed(), e.exp);
      end
      bus.mem_ack  = e.ack;
      bus.step     = e.stp;
      bus.ir_value = e.ir;
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    trace.delete();
  endtask

  // Apply reset for one edge and check the reset state.
  // Then release it while mem_ack is high, which must be ignored.
  task automatic do_reset(input string name);
    reset        = 1'b1;
    bus.mem_ack  = 1'($urandom);
    bus.step     = 1'($urandom);
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (observed() !== 21'h0) begin
      n_fail++;
      $display("FAIL %s reset_state: got %06h expected %06h", name, observed(), 21'h0);
    end
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (observed() !== 21'h100000) begin
      n_fail++;
      $display("FAIL %s post_release: got %06h expected %06h", name, observed(), 21'h100000);
    end
    model_count  = 8'h00;
    pend_illegal = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    $display("[TB] test_reset done");
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) add_instr(8'h00, 0, 0, 0);
    run_trace("nop", 1000);
    $display("[TB] test_nop done, model count %0d", model_count);
  endtask

  task automatic test_alu();
    add_instr(8'h25, 0, 0, 0);
    add_instr(8'h30, 1, 0, 0);
    add_instr(8'h00, 0, 0, 0);
    run_trace("alu_out", 1000);
    $display("[TB] test_alu done");
  endtask

  task automatic test_lda_wait();
    add_instr(8'h1A, 0, 3, 0);
    add_instr(8'h00, 0, 0, 0);
    run_trace("lda_wait", 1000);
    $display("[TB] test_lda_wait done");
  endtask

  task automatic test_illegal();
    add_instr(8'h70, 0, 0, 0);
    add_instr(8'h00, 0, 0, 0);
    run_trace("illegal", 1000);
    $display("[TB] test_illegal done");
  endtask

  task automatic test_random();
    logic [7:0] ir;
    int         sel;
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 4));
      ir  = 8'($urandom);
      if (sel < 4) ir[7:4] = 4'(sel);
      else ir[7:4] = 4'($urandom_range(4, 14));
      add_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end
    add_instr(8'h00, 0, 0, 0);
    run_trace("random", 10000);
    $display("[TB] test_random done, model count %0d", model_count);
  endtask

  task automatic test_wrap();
    do_reset("wrap");
    for (int i = 0; i < 257; i++) add_instr(8'h00, 0, 0, 0);
    run_trace("wrap", 10000);
    $display("[TB] test_wrap done, model count %0d", model_count);
  endtask

  task automatic test_reset_mid();
    add_instr(8'h00, 6, 0, 0);
    run_trace("fetch_wait", 3);
    do_reset("reset_mid");
    add_instr(8'h00, 0, 0, 0);
    run_trace("after_reset_mid", 1000);
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_halt();
    add_instr(8'hF0, 0, 25, 0);
    run_trace("halt", 1000);
    do_reset("halt_reset");
    add_instr(8'h00, 0, 0, 0);
    run_trace("after_halt", 1000);
    $display("[TB] test_halt done");
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic test_single_step();
    add_instr(8'h00, 0, 0, 10);
    add_instr(8'h25, 0, 0, 4);
    add_instr(8'h00, 0, 0, 0);
    run_trace("single_step", 1000);
    $display("[TB] test_single_step done");
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bus.mem_ack  = 1'b0;
    bus.step     = 1'b0;
    bus.ir_value = 8'h00;
    model_count  = 8'h00;
    pend_illegal = 1'b0;
    @(negedge clock);
    test_reset();
    test_nop();
    test_alu();
    test_lda_wait();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid();
    test_halt();
`ifdef CTRL_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
